cla_adder_pipelined: RTL
========================

CLA_ADDER_PIPELINED -- requirements
Module: cla_adder_pipelined

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter BLOCK, default 4, bits per carry-lookahead group.
REQ-003 SHALL have parameter STAGES, default 2, number of pipeline register stages (1..WIDTH/BLOCK).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  operand set present.
REQ-007 SHALL have port in_ready  output  1  block can accept operands this cycle.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port cin  input  1  carry in.
REQ-011 SHALL have port op_sub  input  1  0 = add, 1 = subtract.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port sum  output  WIDTH  result.
REQ-015 SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-016 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-017 SHALL have port zero  output  1  sum equals 0.

Function
REQ-018 Add SHALL compute {cout,sum} = a + b + cin; subtract SHALL compute {cout,sum} = a + ~b + cin (cin=1 gives a-b, cout=1 means no borrow).
REQ-019 Each BLOCK slice SHALL form per-bit p = a^b', g = a&b' and group P/G; carries within a stage SHALL be lookahead (group P/G), no bit-serial ripple across more than BLOCK bits.
REQ-020 Operand is split into STAGES equal chunks, LSB chunk first; stage k SHALL compute chunk k using the registered carry from stage k-1; unprocessed upper operand bits and processed lower sum bits SHALL travel skewed in the stage registers.
REQ-021 ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1; zero SHALL equal ~|sum.
REQ-022 Transfer in: in_valid & in_ready at a rising edge; transfer out: out_valid & out_ready.
REQ-023 Latency SHALL be exactly STAGES cycles from input transfer to out_valid when not stalled; throughput SHALL be one result per cycle.
REQ-024 Each stage SHALL hold a valid bit; a stage SHALL advance when its successor is empty or advancing; in_ready SHALL be (!stage0_valid | stage0_advances), with no combinational path from in_valid to in_ready.
REQ-025 While out_valid=1 and out_ready=0, sum/cout/ovf/zero SHALL remain stable and no stage holding valid data SHALL be overwritten.
REQ-026 Results SHALL exit in acceptance order; no result dropped or duplicated.
REQ-027 Pipeline full and output stalled: in_ready=0; out_ready asserted that cycle: in_ready=1 same cycle (simultaneous in/out transfer allowed).
REQ-028 Operands with in_valid=0 SHALL be ignored; output data with out_valid=0 is don't-care but SHALL not toggle X.

Reset
REQ-029 rst_n low SHALL immediately clear all stage valid bits, out_valid=0, sum=0, cout=0, ovf=0, zero=0; in_ready=1 one cycle after rst_n deasserts.
REQ-030 Reset mid-operation SHALL discard all in-flight transactions; none SHALL appear after reset.

Structure
REQ-031 Package cla_pkg SHALL hold op_e enum (OP_ADD=0, OP_SUB=1), default WIDTH/BLOCK/STAGES constants and the legality function WIDTH % (BLOCK*STAGES) == 0.
REQ-032 Illegal parameter combinations SHALL fail elaboration.
REQ-033 One sub-module cla_block (BLOCK-bit lookahead slice: inputs a, b, cin; outputs sum, group P, group G, cout) SHALL be instantiated WIDTH/BLOCK times.

Verification (WIDTH=16, BLOCK=4, STAGES=2, out_ready=1 unless stated)
REQ-034 ADD 0xFFFF+0x0001, cin=0 -> 2 cycles later sum=0x0000, cout=1, zero=1, ovf=0.
REQ-035 ADD 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1, zero=0.
REQ-036 SUB 0x8000-0x0001, cin=1 -> sum=0x7FFF, cout=1, ovf=1; SUB 0x0000-0x0001, cin=1 -> sum=0xFFFF, cout=0, ovf=0.
REQ-037 Five back-to-back inputs, out_ready=0 for cycles 2-6 -> in_ready drops after 2 accepted, first result held stable, all five emerge in order after release.
REQ-038 rst_n pulsed low with 2 transactions in flight -> out_valid=0 at once, no stale result emerges afterwards.
REQ-039 10k random a/b/cin/op_sub with random in_valid/out_ready -> every result matches reference model, order preserved.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and parameter checks for the pipelined carry-lookahead adder.
// Contents:
//   op_e              - operation select encoding (add / subtract)
//   CLA_WIDTH/BLOCK/STAGES - default geometry
//   cla_params_legal  - true when the geometry splits evenly into stages and groups
package cla_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned CLA_WIDTH  = 32;
  localparam int unsigned CLA_BLOCK  = 4;
  localparam int unsigned CLA_STAGES = 2;

  // Every stage must hold a whole number of lookahead groups, and there can be
  // no more stages than groups.
  function automatic bit cla_params_legal(int unsigned width, int unsigned block,
                                          int unsigned stages);
    if (block == 0 || stages == 0 || width == 0) return 1'b0;
    if ((width % (block * stages)) != 0) return 1'b0;
    return stages <= (width / block);
  endfunction

endpackage

// File: rtl/cla_block.sv
// BLOCK-bit carry-lookahead slice.
// Ports:
//   a, b   - slice operands (b already conditioned for subtract by the caller)
//   cin    - carry into bit 0 of the slice
//   sum    - slice sum
//   p_grp  - group propagate (all bits propagate)
//   g_grp  - group generate (slice generates a carry regardless of cin)
//   cout   - carry out of the slice top bit
module cla_block import cla_pkg::*; #(
  parameter int unsigned BLOCK = CLA_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             p_grp,
  output logic             g_grp,
  output logic             cout
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK:0]   c;
  logic             grp_g;
  logic             grp_p;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is built as a flat sum of products: g[i-1] | p[i-1]g[i-2] | ...
  // | p[i-1..0]cin, so no carry waits on a lower carry inside the slice.
  always_comb begin
    logic acc;
    logic pr;
    acc   = 1'b0;
    pr    = 1'b1;
    grp_g = 1'b0;
    grp_p = 1'b1;
    c     = '0;
    c[0]  = cin;
    for (int unsigned i = 1; i <= BLOCK; i++) begin
      acc = 1'b0;
      pr  = 1'b1;
      for (int unsigned j = i; j > 0; j--) begin
        acc = acc | (pr & g[j-1]);
        pr  = pr & p[j-1];
      end
      c[i] = acc | (pr & cin);
      if (i == BLOCK) begin
        grp_g = acc;
        grp_p = pr;
      end
    end
  end

  assign sum   = p ^ c[BLOCK-1:0];
  assign p_grp = grp_p;
  assign g_grp = grp_g;
  assign cout  = c[BLOCK];

endmodule

// File: rtl/cla_adder_pipelined.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// The operand is cut into STAGES equal chunks, least significant first. Stage k
// sums chunk k with lookahead over BLOCK-bit groups and registers the result,
// its carry, the already-finished lower sum bits and the still-unsummed upper
// operand bits. The last stage register drives the outputs.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - input handshake for a, b, cin, op_sub
//   a, b, cin, op_sub   - operands, carry in, 0 = add / 1 = subtract (a + ~b + cin)
//   out_valid/out_ready - output handshake
//   sum, cout, ovf, zero - result, carry out, signed overflow, sum == 0
module cla_adder_pipelined import cla_pkg::*; #(
  parameter int unsigned WIDTH  = CLA_WIDTH,
  parameter int unsigned BLOCK  = CLA_BLOCK,
  parameter int unsigned STAGES = CLA_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam bit          LEGAL = cla_params_legal(WIDTH, BLOCK, STAGES);
  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned BPC   = CHUNK / BLOCK;

  if (!LEGAL) begin : g_illegal
    $error("cla_adder_pipelined: WIDTH must be a multiple of BLOCK*STAGES");
  end

  op_e              op;
  logic [WIDTH-1:0] b_eff;

  assign op    = op_e'(op_sub);
  assign b_eff = (op == OP_SUB) ? ~b : b;

  // ---------------------------------------------------------------------------
  // Flow control: free[k] means stage k may load this cycle (it is empty or its
  // content moves on). Built from the output side only, so in_ready never
  // depends on in_valid.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] free;

  always_comb begin
    free             = '0;
    free[STAGES-1]   = !v[STAGES-1] | out_ready;
    for (int unsigned i = 1; i < STAGES; i++) begin
      free[STAGES-1-i] = !v[STAGES-1-i] | free[STAGES-i];
    end
  end

  assign in_ready = free[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else begin
      if (free[0]) v[0] <= in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (free[k]) v[k] <= v[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath stages
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits not yet summed when data enters this stage.
    localparam int unsigned REM = WIDTH - k * CHUNK;

    logic [REM-1:0]         ra;
    logic [REM-1:0]         rb;
    logic                   rc;
    logic                   load;
    logic [CHUNK-1:0]       cs;
    logic                   co;
    logic [(k+1)*CHUNK-1:0] sum_d;
    logic [(k+1)*CHUNK-1:0] sum_q;
    logic                   carry_q;

    if (k == 0) begin : g_src
      assign ra    = a;
      assign rb    = b_eff;
      assign rc    = cin;
      assign load  = free[0] & in_valid;
      assign sum_d = cs;
    end else begin : g_src
      assign ra    = g_stage[k-1].g_fwd.a_q;
      assign rb    = g_stage[k-1].g_fwd.b_q;
      assign rc    = g_stage[k-1].carry_q;
      assign load  = free[k] & v[k-1];
      assign sum_d = {cs, g_stage[k-1].sum_q};
    end

    // Group lookahead across the slices of this chunk.
    logic [BPC-1:0] bp;
    logic [BPC-1:0] bg;
    logic [BPC-1:0] bc;
    logic [BPC:0]   c;

    for (genvar j = 0; j < BPC; j++) begin : g_blk
      cla_block #(.BLOCK(BLOCK)) u_blk (
        .a     (ra[j*BLOCK +: BLOCK]),
        .b     (rb[j*BLOCK +: BLOCK]),
        .cin   (c[j]),
        .sum   (cs[j*BLOCK +: BLOCK]),
        .p_grp (bp[j]),
        .g_grp (bg[j]),
        .cout  (bc[j])
      );
    end

    always_comb begin
      logic acc;
      logic pr;
      acc  = 1'b0;
      pr   = 1'b1;
      c    = '0;
      c[0] = rc;
      for (int unsigned i = 1; i <= BPC; i++) begin
        acc = 1'b0;
        pr  = 1'b1;
        for (int unsigned j = i; j > 0; j--) begin
          acc = acc | (pr & bg[j-1]);
          pr  = pr & bp[j-1];
        end
        c[i] = acc | (pr & rc);
      end
    end

    assign co = c[BPC];

    // The slice carry-outs are redundant with the group lookahead carries.
    a_slice_carry_agrees: assert property (@(posedge clk) disable iff (!rst_n)
      bc == c[BPC:1]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (load) begin
        sum_q   <= sum_d;
        carry_q <= co;
      end
    end

    // Upper operand bits ride along, skewed, until their stage sums them.
    if (k < STAGES - 1) begin : g_fwd
      logic [REM-CHUNK-1:0] a_q;
      logic [REM-CHUNK-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load) begin
          a_q <= ra[REM-1:CHUNK];
          b_q <= rb[REM-1:CHUNK];
        end
      end
    end else begin : g_out
      logic ovf_d;
      logic zero_d;
      logic ovf_q;
      logic zero_q;
      // Carry into the MSB recovered as sum ^ a ^ b at that bit.
      assign ovf_d  = co ^ (cs[CHUNK-1] ^ ra[CHUNK-1] ^ rb[CHUNK-1]);
      assign zero_d = ~|sum_d;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (load) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].carry_q;
  assign ovf       = g_stage[STAGES-1].g_out.ovf_q;
  assign zero      = g_stage[STAGES-1].g_out.zero_q;

endmodule
